// File: rtl/loop_step_sequencer.sv
// Looping step sequencer: circular pattern, tempo divider, step index and
// per-step gate timing that enables the tone oscillator.
module loop_step_sequencer #(
    parameter int unsigned             STEPS   = 16,
    parameter int unsigned             TEMPO_W = 24,
    parameter logic [STEPS-1:0]        PRESET  = STEPS'(16'h4444)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       rewind,
    input  logic [TEMPO_W-1:0]         tempo_div,
    input  logic [TEMPO_W-1:0]         gate_len,
    input  logic                       set_btn,
    input  logic                       clear_btn,
    input  logic                       load,
    input  logic [STEPS-1:0]           pattern_in,
    output logic [STEPS-1:0]           pattern,
    output logic [$clog2(STEPS)-1:0]   step_idx,
    output logic                       step_tick,
    output logic                       gate
);

    localparam int unsigned IDX_W = $clog2(STEPS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TEMPO_W-1:0] tick_cnt;
    logic [TEMPO_W-1:0] tick_cnt_d;
    logic [IDX_W-1:0]   step_idx_d;
    logic               step_tick_d;
    logic               gate_d;
    logic [STEPS-1:0]   pattern_d;

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tick_cnt  <= '0;
            step_idx  <= '0;
            step_tick <= 1'b0;
            gate      <= 1'b0;
            pattern   <= PRESET;
        end else begin
            state_q   <= state_d;
            tick_cnt  <= tick_cnt_d;
            step_idx  <= step_idx_d;
            step_tick <= step_tick_d;
            gate      <= gate_d;
            pattern   <= pattern_d;
        end
    end

    // Next state, step timer, pattern edits and gate
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt;
        step_idx_d  = step_idx;
        step_tick_d = 1'b0;
        gate_d      = 1'b0;
        pattern_d   = pattern;

        unique case (state_q)
            IDLE:    if (run)  state_d = RUN;
            RUN:     if (!run) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Rewind wins over a coincident step advance and emits no tick
        if (rewind) begin
            tick_cnt_d = '0;
            step_idx_d = '0;
        end else if (state_q == RUN) begin
            // >= so a tempo shortened mid-step ticks on the next cycle
            if (tick_cnt >= tempo_div) begin
                tick_cnt_d  = '0;
                step_idx_d  = step_idx + IDX_W'(1);
                step_tick_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt + TEMPO_W'(1);
            end
        end

        // Edits target the current (pre-advance) step, also while paused
        if (load) begin
            pattern_d = pattern_in;
        end else if (clear_btn) begin
            pattern_d[step_idx] = 1'b0;
        end else if (set_btn) begin
            pattern_d[step_idx] = 1'b1;
        end

        gate_d = (state_q == RUN) && pattern[step_idx] && (tick_cnt < gate_len);
    end

endmodule
